// File: rtl/coco_ram_arbiter.sv
// coco_ram_arbiter
//   Shares one single-port 64K RAM between VDG video fetch, the 6809 CPU and
//   the ioctl download path. A fixed IDLE -> ACCESS -> CAPTURE sequencer
//   performs one access at a time, so the RAM can map to one-port BRAM/SRAM.
//
//   Optional build macro: COCO_ARB_STATS_EN adds 16-bit per-requester grant
//   counters (stat_vdg, stat_cpu, stat_dl). Without it the ports and counters
//   are absent and the arbiter behaves identically.
//
//   Handshake: each requester raises a level req with stable operands and
//   keeps them until its ack, a single-cycle pulse. A req still high at the
//   edge that ends the ack cycle counts as a fresh request. Dropping req after
//   the grant does not cancel the access; the ack still pulses.
//
//   Priority VDG > CPU > DL, except that a CPU which has lost STARVE_LIMIT
//   consecutive arbitrations wins over the VDG once.
//
//   dbg_state encoding: 0 = IDLE, 1 = ACCESS, 2 = CAPTURE.
module coco_ram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  // video fetch (read only)
  input  logic              vdg_req,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic              vdg_ack,
  output logic [DATA_W-1:0] vdg_rdata,
  // CPU
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // download (write only)
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_wdata,
  output logic              dl_ack,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q,
  // sequencer state for observation
  output logic [1:0]        dbg_state
`ifdef COCO_ARB_STATS_EN
  ,
  output logic [15:0]       stat_vdg,
  output logic [15:0]       stat_cpu,
  output logic [15:0]       stat_dl
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WIN_VDG  = 2'd0,
    WIN_CPU  = 2'd1,
    WIN_DL   = 2'd2,
    WIN_NONE = 2'd3
  } win_t;

  state_t              state_q,     state_d;
  win_t                win_q,       win_d;
  win_t                pick;
  logic                wr_q,        wr_d;
  logic [7:0]          starve_q,    starve_d;
  logic                starve_hit;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                vdg_ack_q,   vdg_ack_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                dl_ack_q,    dl_ack_d;
  logic [DATA_W-1:0]   vdg_rdata_q, vdg_rdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
`ifdef COCO_ARB_STATS_EN
  logic [15:0]         stat_vdg_q,  stat_vdg_d;
  logic [15:0]         stat_cpu_q,  stat_cpu_d;
  logic [15:0]         stat_dl_q,   stat_dl_d;
`endif

  // CPU has waited long enough to outrank the video fetch
  assign starve_hit = (32'(starve_q) >= 32'(STARVE_LIMIT));

  // Next-state logic: arbitration in IDLE, RAM strobe drop in ACCESS,
  // data capture and ack in CAPTURE.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    wr_d        = wr_q;
    starve_d    = starve_q;
    pick        = WIN_NONE;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    vdg_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    dl_ack_d    = 1'b0;
    vdg_rdata_d = vdg_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef COCO_ARB_STATS_EN
    stat_vdg_d  = stat_vdg_q;
    stat_cpu_d  = stat_cpu_q;
    stat_dl_d   = stat_dl_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && starve_hit) begin
          pick = WIN_CPU;
        end else if (vdg_req) begin
          pick = WIN_VDG;
        end else if (cpu_req) begin
          pick = WIN_CPU;
        end else if (dl_req) begin
          pick = WIN_DL;
        end

        // count consecutive CPU losses; any grant or idle CPU clears it
        if (cpu_req && (pick != WIN_CPU)) begin
          starve_d = (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
        end else begin
          starve_d = 8'd0;
        end

        case (pick)
          WIN_VDG: begin
            mem_addr_d = vdg_addr;
            wr_d       = 1'b0;
          end
          WIN_CPU: begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            wr_d        = cpu_we;
          end
          WIN_DL: begin
            mem_addr_d  = dl_addr;
            mem_wdata_d = dl_wdata;
            wr_d        = 1'b1;
          end
          default: ;
        endcase

        if (pick != WIN_NONE) begin
          state_d  = ST_ACCESS;
          win_d    = pick;
          mem_en_d = 1'b1;
          mem_we_d = wr_d;
`ifdef COCO_ARB_STATS_EN
          case (pick)
            WIN_VDG: stat_vdg_d = stat_vdg_q + 16'd1;
            WIN_CPU: stat_cpu_d = stat_cpu_q + 16'd1;
            WIN_DL:  stat_dl_d  = stat_dl_q + 16'd1;
            default: ;
          endcase
`endif
        end
      end

      ST_ACCESS: begin
        // RAM latches the strobes at the end of this cycle; drop them after
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // mem_q now carries the read data for the access in flight
        state_d = ST_IDLE;
        case (win_q)
          WIN_VDG: begin
            vdg_rdata_d = mem_q;
            vdg_ack_d   = 1'b1;
          end
          WIN_CPU: begin
            if (!wr_q) begin
              cpu_rdata_d = mem_q;
            end
            cpu_ack_d = 1'b1;
          end
          WIN_DL: begin
            dl_ack_d = 1'b1;
          end
          default: ;
        endcase
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset abandons
  // any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      win_q       <= WIN_NONE;
      wr_q        <= 1'b0;
      starve_q    <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vdg_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dl_ack_q    <= 1'b0;
      vdg_rdata_q <= '0;
      cpu_rdata_q <= '0;
`ifdef COCO_ARB_STATS_EN
      stat_vdg_q  <= 16'd0;
      stat_cpu_q  <= 16'd0;
      stat_dl_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vdg_ack_q   <= vdg_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      dl_ack_q    <= dl_ack_d;
      vdg_rdata_q <= vdg_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef COCO_ARB_STATS_EN
      stat_vdg_q  <= stat_vdg_d;
      stat_cpu_q  <= stat_cpu_d;
      stat_dl_q   <= stat_dl_d;
`endif
    end
  end

  assign vdg_ack   = vdg_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign dl_ack    = dl_ack_q;
  assign vdg_rdata = vdg_rdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;
`ifdef COCO_ARB_STATS_EN
  assign stat_vdg  = stat_vdg_q;
  assign stat_cpu  = stat_cpu_q;
  assign stat_dl   = stat_dl_q;
`endif

endmodule

// File: tb/tb_coco_ram_arbiter.sv
// Bench for coco_ram_arbiter: directed vector table, hand-written priority /
// starvation / reset sequences, and concurrent random requesters checked
// against a shadow memory and a CPU wait bound.
`timescale 1ns/1ps
module tb_coco_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SL = 8;
  localparam int VDG = 0;
  localparam int CPU = 1;
  localparam int DL  = 2;
  // worst CPU wait: finish the current access, lose SL rounds, then its own
  localparam int CPU_BOUND = 3 * (SL + 2) + 3;

  logic          clk, reset;
  logic          vdg_req, vdg_ack;
  logic [AW-1:0] vdg_addr;
  logic [DW-1:0] vdg_rdata;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dl_req, dl_ack;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_wdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_q;
  logic [1:0]    dbg_state;
`ifdef COCO_ARB_STATS_EN
  logic [15:0]   stat_vdg, stat_cpu, stat_dl;
`endif

  coco_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk       (clk),
    .reset     (reset),
    .vdg_req   (vdg_req),
    .vdg_addr  (vdg_addr),
    .vdg_ack   (vdg_ack),
    .vdg_rdata (vdg_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dl_req    (dl_req),
    .dl_addr   (dl_addr),
    .dl_wdata  (dl_wdata),
    .dl_ack    (dl_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_q     (mem_q),
    .dbg_state (dbg_state)
`ifdef COCO_ARB_STATS_EN
    ,
    .stat_vdg  (stat_vdg),
    .stat_cpu  (stat_cpu),
    .stat_dl   (stat_dl)
`endif
  );

  int total, bad;
  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];
  logic [DW-1:0] cpu_exp_q[$];
  logic [DW-1:0] vdg_exp_q[$];
  logic [7:0] m_cpu_rd, m_vdg_rd;

  typedef struct {
    int         who;
    bit         we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[13];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_q <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // at most one ack may be high in any cycle
  always @(negedge clk) begin
    if (reset && (vdg_ack || cpu_ack || dl_ack))
      check("one_ack_per_cycle", 32'(vdg_ack) + 32'(cpu_ack) + 32'(dl_ack), 1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int who, input bit on, input bit we,
                           input logic [15:0] addr, input logic [7:0] wd);
    case (who)
      VDG: begin vdg_req = on; vdg_addr = addr; end
      CPU: begin cpu_req = on; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
      default: begin dl_req = on; dl_addr = addr; dl_wdata = wd; end
    endcase
  endtask

  function automatic logic ack_of(input int who);
    if (who == VDG) return vdg_ack;
    if (who == CPU) return cpu_ack;
    return dl_ack;
  endfunction

  function automatic logic [7:0] rdata_of(input int who);
    if (who == VDG) return vdg_rdata;
    if (who == CPU) return cpu_rdata;
    return 8'h00;
  endfunction

  // one isolated access: latency counted in edges from the sampling edge
  task automatic single_txn(input int who, input bit we, input logic [15:0] addr,
                            input logic [7:0] wd, output logic [7:0] rd,
                            output int lat, output int we_cyc, output int we_cnt);
    int n;
    bit got;
    @(negedge clk);
    drive_req(who, 1'b1, we, addr, wd);
    n = 0; got = 1'b0; we_cnt = 0; we_cyc = -1;
    while (!got && n < 50) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (mem_we) begin we_cnt++; we_cyc = n; end
      if (ack_of(who)) got = 1'b1;
    end
    rd  = rdata_of(who);
    lat = got ? n : -1;
    drive_req(who, 1'b0, we, addr, wd);
  endtask

  task automatic drop_all();
    vdg_req = 1'b0; cpu_req = 1'b0; dl_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int va, ca, vb, vc, cn, dd, dl_early, dl_at, ack_seen, dl_late;
  int lat, wc, wn;
  logic [7:0] rd;

  initial begin
    total = 0; bad = 0;
    reset = 1'b0;
    drop_all();
    vdg_addr = '0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dl_addr = '0; dl_wdata = '0;
    for (int i = 0; i < 65536; i++) begin ram[i] = 8'h00; shadow[i] = 8'h00; end
    m_cpu_rd = 8'h00; m_vdg_rd = 8'h00;

    vecs[0]  = '{CPU, 1'b1, 16'h0400, 8'hA5, 8'h00};
    vecs[1]  = '{CPU, 1'b0, 16'h0400, 8'h00, 8'hA5};
    vecs[2]  = '{DL,  1'b1, 16'hC010, 8'h3C, 8'h00};
    vecs[3]  = '{VDG, 1'b0, 16'hC010, 8'h00, 8'h3C};
    vecs[4]  = '{CPU, 1'b1, 16'hFFFF, 8'h5A, 8'h00};
    vecs[5]  = '{CPU, 1'b0, 16'hFFFF, 8'h00, 8'h5A};
    vecs[6]  = '{VDG, 1'b0, 16'hFFFF, 8'h00, 8'h5A};
    vecs[7]  = '{VDG, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[8]  = '{CPU, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[9]  = '{DL,  1'b1, 16'h0000, 8'hC3, 8'h00};
    vecs[10] = '{VDG, 1'b0, 16'h0000, 8'h00, 8'hC3};
    vecs[11] = '{CPU, 1'b1, 16'h0000, 8'h11, 8'h00};
    vecs[12] = '{CPU, 1'b0, 16'h0000, 8'h00, 8'h11};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_acks", {vdg_ack, cpu_ack, dl_ack}, 0);
    check("rst_vdg_rdata", vdg_rdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b1;

    // isolated accesses from the vector table
    for (int i = 0; i < 13; i++) begin
      single_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, wc, wn);
      check("vec_latency", lat, 3);
      check("vec_we_count", wn, vecs[i].we ? 1 : 0);
      if (vecs[i].we) begin
        check("vec_we_cycle", wc, 1);
        shadow[vecs[i].addr] = vecs[i].wdata;
      end else if (vecs[i].who == VDG) begin
        m_vdg_rd = vecs[i].exp;
      end else begin
        m_cpu_rd = vecs[i].exp;
      end
      check("vec_vdg_rdata", vdg_rdata, m_vdg_rd);
      check("vec_cpu_rdata", cpu_rdata, m_cpu_rd);
    end

    // VDG and CPU at the same edge: VDG first, CPU next
    @(negedge clk);
    drive_req(VDG, 1'b1, 1'b0, 16'h0400, 8'h00);
    drive_req(CPU, 1'b1, 1'b0, 16'h0000, 8'h00);
    va = -1; ca = -1;
    for (int n = 1; n <= 20 && ca < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (vdg_ack && va < 0) begin va = n; vdg_req = 1'b0; end
      if (cpu_ack) begin ca = n; cpu_req = 1'b0; end
    end
    drop_all();
    check("prio_vdg_ack", va, 3);
    check("prio_cpu_ack", ca, 6);
    check("prio_vdg_rdata", vdg_rdata, 8'hA5);
    check("prio_cpu_rdata", cpu_rdata, 8'h11);

    // VDG held continuously: CPU wins once after SL losses
    @(negedge clk);
    drive_req(VDG, 1'b1, 1'b0, 16'h0400, 8'h00);
    drive_req(CPU, 1'b1, 1'b0, 16'hFFFF, 8'h00);
    vc = 0; ca = -1; vb = -1; va = -1;
    for (int n = 1; n <= 60 && va < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (cpu_ack && ca < 0) begin ca = n; vb = vc; cpu_req = 1'b0; end
      if (vdg_ack) begin
        if (ca < 0) vc++;
        else begin va = n; vdg_req = 1'b0; end
      end
    end
    drop_all();
    repeat (4) @(negedge clk);
    check("starve_vdg_before", vb, SL);
    check("starve_cpu_ack", ca, 3 * (SL + 1));
    check("starve_vdg_resume", va, 3 * (SL + 2));
    check("starve_cpu_rdata", cpu_rdata, 8'h5A);

    // download fill, CPU read-back
    dl_late = 0;
    for (int i = 0; i < 256; i++) begin
      single_txn(DL, 1'b1, 16'(32'hC000 + i), i[7:0], rd, lat, wc, wn);
      if (lat != 3) dl_late++;
      shadow[16'(32'hC000 + i)] = i[7:0];
    end
    check("dl_fill_latency_errors", dl_late, 0);
    single_txn(CPU, 1'b0, 16'hC010, 8'h00, rd, lat, wc, wn);
    check("dl_readback", rd, 8'h10);

    // held CPU blocks download until released
    @(negedge clk);
    drive_req(CPU, 1'b1, 1'b0, 16'hC010, 8'h00);
    drive_req(DL, 1'b1, 1'b1, 16'hC100, 8'h99);
    cn = 0; dd = -1; dl_early = 0; dl_at = -1;
    for (int n = 1; n <= 40 && dl_at < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (dl_ack) begin
        if (dd < 0) dl_early++;
        else dl_at = n - dd;
        dl_req = 1'b0;
      end
      if (cpu_ack) begin
        cn++;
        if (cn == 4) begin dd = n; cpu_req = 1'b0; end
      end
    end
    drop_all();
    shadow[16'hC100] = 8'h99;
    check("dl_blocked_by_cpu", dl_early, 0);
    check("cpu_held_acks", cn, 4);
    check("dl_after_cpu_release", dl_at, 3);
    check("cpu_held_rdata", cpu_rdata, 8'h10);

    // reset in the ACCESS cycle of a CPU write
    @(negedge clk);
    drive_req(CPU, 1'b1, 1'b1, 16'h0500, 8'h77);
    @(posedge clk); @(negedge clk);
    check("rstmid_we_in_access", mem_we, 1);
    reset = 1'b0;
    cpu_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstmid_mem_we", mem_we, 0);
    check("rstmid_mem_en", mem_en, 0);
    check("rstmid_state", dbg_state, 0);
    check("rstmid_cpu_ack", cpu_ack, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    check("rstmid_cpu_rdata", cpu_rdata, 0);
    check("rstmid_vdg_rdata", vdg_rdata, 0);
    reset = 1'b1;
    ack_seen = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (vdg_ack || cpu_ack || dl_ack) ack_seen++;
    end
    check("rstmid_no_ack", ack_seen, 0);

`ifdef COCO_ARB_STATS_EN
    check("stat_vdg_rst", stat_vdg, 0);
    for (int i = 0; i < 3; i++) single_txn(VDG, 1'b0, 16'h0400, 8'h00, rd, lat, wc, wn);
    for (int i = 0; i < 2; i++) single_txn(CPU, 1'b0, 16'h0400, 8'h00, rd, lat, wc, wn);
    single_txn(DL, 1'b1, 16'hC101, 8'h42, rd, lat, wc, wn);
    shadow[16'hC101] = 8'h42;
    check("stat_vdg", stat_vdg, 3);
    check("stat_cpu", stat_cpu, 2);
    check("stat_dl", stat_dl, 1);
`endif

    // concurrent random requesters against the shadow memory
    @(negedge clk);
    fork
      begin : cpu_drv
        logic [15:0] a; logic [7:0] d; bit w; int n; bit got; logic [7:0] e;
        for (int k = 0; k < 40; k++) begin
          a = 16'(32'h0400 + $urandom_range(0, 15));
          w = 1'($urandom_range(0, 1));
          d = 8'($urandom);
          if (w) shadow[a] = d; else cpu_exp_q.push_back(shadow[a]);
          drive_req(CPU, 1'b1, w, a, d);
          n = 0; got = 1'b0;
          while (!got && n < 200) begin @(posedge clk); @(negedge clk); n++; got = cpu_ack; end
          drive_req(CPU, 1'b0, w, a, d);
          check("rnd_cpu_wait_in_bound", {31'd0, (got && n <= CPU_BOUND)}, 1);
          if (!w) begin
            e = cpu_exp_q.pop_front();
            if (got) check("rnd_cpu_rdata", cpu_rdata, e);
          end
          repeat ($urandom_range(1, 4)) @(negedge clk);
        end
      end
      begin : vdg_drv
        logic [15:0] a; int n; bit got; logic [7:0] e;
        for (int k = 0; k < 40; k++) begin
          a = 16'(32'hC000 + $urandom_range(0, 255));
          vdg_exp_q.push_back(shadow[a]);
          drive_req(VDG, 1'b1, 1'b0, a, 8'h00);
          n = 0; got = 1'b0;
          while (!got && n < 200) begin @(posedge clk); @(negedge clk); n++; got = vdg_ack; end
          drive_req(VDG, 1'b0, 1'b0, a, 8'h00);
          e = vdg_exp_q.pop_front();
          check("rnd_vdg_acked", {31'd0, got}, 1);
          if (got) check("rnd_vdg_rdata", vdg_rdata, e);
          repeat ($urandom_range(1, 4)) @(negedge clk);
        end
      end
      begin : dl_drv
        logic [15:0] a; logic [7:0] d; int n; bit got;
        for (int k = 0; k < 30; k++) begin
          a = 16'(32'hD000 + $urandom_range(0, 31));
          d = 8'($urandom);
          shadow[a] = d;
          drive_req(DL, 1'b1, 1'b1, a, d);
          n = 0; got = 1'b0;
          while (!got && n < 400) begin @(posedge clk); @(negedge clk); n++; got = dl_ack; end
          drive_req(DL, 1'b0, 1'b1, a, d);
          check("rnd_dl_acked", {31'd0, got}, 1);
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
      end
    join
    drop_all();
    repeat (4) @(negedge clk);

    // read back download region through the CPU
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      a = 16'(32'hD000 + $urandom_range(0, 31));
      single_txn(CPU, 1'b0, a, 8'h00, rd, lat, wc, wn);
      check("rnd_dl_readback", rd, shadow[a]);
      check("rnd_readback_latency", lat, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
